// File: rtl/conv_frame_scheduler.sv
// Frame sequencer for the 5x5 convolution unit: raster-scans the output frame, gathers each
// zero-padded neighbourhood from the source RAM, runs the convolution and stores the result byte.
module conv_frame_scheduler #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_sel,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic [199:0]      conv_window,
  output logic [1:0]        conv_sel,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [23:0]       conv_result
);

  localparam int ROW_W = (IMG_H > 32'sd1) ? $clog2(IMG_H) : 32'sd1;
  localparam int COL_W = (IMG_W > 32'sd1) ? $clog2(IMG_W) : 32'sd1;
  localparam int KW    = 32'sd5;
  localparam int HALF  = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_CONV     = 3'd2,
    ST_WAIT_LOW = 3'd3,
    ST_WRITE    = 3'd4,
    ST_NEXT     = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [4:0]          k_q, k_d;
  logic [1:0]          sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                conv_start_q, conv_start_d;
  logic [7:0]          result_q, result_d;
  logic                inb_q, inb_d;
  logic                cap_inb_q, cap_inb_d;
  logic [7:0]          win_q [25];
  logic [7:0]          win_d [25];
  logic                issue_s;
  logic [ADDR_W:0]     tap_s;
  logic [4:0]          cap_idx_s;
  logic                unused_s;

  // Returns {in_bounds, address} of tap k of the window centred on (row, col).
  function automatic logic [ADDR_W:0] tap_info(input int row, input int col, input int k);
    int   y;
    int   x;
    logic inb;
    y   = row + k / KW - HALF;
    x   = col + k % KW - HALF;
    inb = (y >= 32'sd0) && (y < IMG_H) && (x >= 32'sd0) && (x < IMG_W);
    return {inb, ADDR_W'(y * IMG_W + x)};
  endfunction

  assign unused_s = ^conv_result[15:8];

  // Next-state, datapath and output computation.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    k_d          = k_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    conv_start_d = 1'b0;
    result_d     = result_q;
    inb_d        = 1'b0;
    cap_inb_d    = inb_q;
    win_d        = win_q;
    issue_s      = 1'b0;
    tap_s        = '0;
    cap_idx_s    = k_q - 5'd1;

    case (state_q)
      ST_IDLE: begin
        // The frame_done cycle is still part of the finished frame.
        if (cmd_start && !frame_done_q) begin
          sel_d   = cmd_sel;
          row_d   = '0;
          col_d   = '0;
          k_d     = 5'd0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
          issue_s = 1'b1;
          tap_s   = tap_info(32'sd0, 32'sd0, 32'sd0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Cycle k captures the tap addressed in cycle k-1 while addressing tap k+1.
        if (k_q != 5'd0) begin
          win_d[cap_idx_s] = cap_inb_q ? rd_data : 8'h00;
        end else begin
          win_d = win_q;
        end
        if (k_q < 5'd24) begin
          issue_s = 1'b1;
          tap_s   = tap_info(int'(row_q), int'(col_q), int'(k_q) + 32'sd1);
        end else begin
          issue_s = 1'b0;
        end
        if (k_q == 5'd25) begin
          k_d          = 5'd0;
          conv_start_d = 1'b1;
          state_d      = ST_CONV;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      ST_CONV: begin
        if (conv_done) begin
          result_d = sel_q[1] ? conv_result[23:16] : conv_result[7:0];
          state_d  = ST_WAIT_LOW;
        end else begin
          conv_start_d = 1'b1;
        end
      end
      ST_WAIT_LOW: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(int'(row_q) * IMG_W + int'(col_q));
        wr_data_d = result_q;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if ((row_q == ROW_W'(IMG_H - 32'sd1)) && (col_q == COL_W'(IMG_W - 32'sd1))) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          row_d        = '0;
          col_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          if (col_q == COL_W'(IMG_W - 32'sd1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1'b1);
          end else begin
            col_d = col_q + COL_W'(1'b1);
          end
          k_d     = 5'd0;
          state_d = ST_FETCH;
          issue_s = 1'b1;
          tap_s   = tap_info(int'(row_d), int'(col_d), 32'sd0);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Out-of-frame taps leave the read address untouched.
    if (issue_s) begin
      inb_d = tap_s[ADDR_W];
      if (tap_s[ADDR_W]) begin
        rd_addr_d = tap_s[ADDR_W-1:0];
      end else begin
        rd_addr_d = rd_addr_q;
      end
    end else begin
      inb_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      k_q          <= 5'd0;
      sel_q        <= 2'b00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      wr_en_q      <= 1'b0;
      conv_start_q <= 1'b0;
      result_q     <= 8'h00;
      inb_q        <= 1'b0;
      cap_inb_q    <= 1'b0;
      win_q        <= '{default: 8'h00};
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      k_q          <= k_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      conv_start_q <= conv_start_d;
      result_q     <= result_d;
      inb_q        <= inb_d;
      cap_inb_q    <= cap_inb_d;
      win_q        <= win_d;
    end
  end

  for (genvar i = 0; i < 25; i++) begin : g_win
    assign conv_window[8*i +: 8] = win_q[i];
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign rd_addr    = rd_addr_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_en      = wr_en_q;
  assign conv_sel   = sel_q;
  assign conv_start = conv_start_q;

endmodule
